// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC rotation (sin/cos) and
// vectoring (atan2/magnitude) engines.
package cordic_pkg;

  localparam int CORDIC_ITERS = 16;
  localparam int XY_W         = 18;
  localparam int Z_W          = 16;

  // atan(2^-i) in Q2.14 radians; from entry 5 on each value halves the previous one
  localparam logic [15:0] ATAN_TABLE [16] = '{
    16'h3244, 16'h1DAC, 16'h0FAE, 16'h07F5, 16'h03FF, 16'h0200, 16'h0100, 16'h0080,
    16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000
  };

  localparam logic [15:0] CORDIC_GAIN   = 16'h26DD;
  localparam int          RAD2DEG_MUL   = 3667;
  localparam int          RAD2DEG_SHIFT = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_POST = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, shared by the rotation and vectoring engines.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] atan_o
);

  assign atan_o = ATAN_TABLE[idx_i];

endmodule

// File: rtl/cordic_atan2_mag.sv
// Iterative CORDIC vectoring engine: (x, y) in Q2.14 -> angle in integer degrees
// plus gain-corrected magnitude, one micro-rotation per clock.
module cordic_atan2_mag
  import cordic_pkg::*;
#(
  parameter int I_MAX = CORDIC_ITERS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] angle_output,
  output logic [15:0] magnitude_output,
  output logic        busy,
  output logic        done
);

  localparam int                    PROD_W    = XY_W + 18;
  localparam logic [3:0]            LAST_ITER = 4'(I_MAX - 1);
  localparam logic signed [31:0]    DEG_ROUND = 32'sd1 <<< (RAD2DEG_SHIFT - 1);
  localparam logic signed [PROD_W-1:0] GAIN_EXT = PROD_W'(CORDIC_GAIN);

  cordic_state_e             state_q;
  logic signed [XY_W-1:0]    x_q, y_q;
  logic signed [Z_W-1:0]     z_q;
  logic [3:0]                iter_q;
  logic signed [15:0]        offset_q;
  logic                      zero_q;
  logic [15:0]               angle_q, mag_q;
  logic                      busy_q, done_q;

  logic [15:0]               atan_w;
  logic signed [Z_W-1:0]     atan_s;
  logic signed [XY_W-1:0]    xi_ext, yi_ext, x_shift, y_shift, x_d, y_d;
  logic signed [Z_W-1:0]     z_d;

  cordic_atan_rom u_atan_rom (
    .idx_i  (iter_q),
    .atan_o (atan_w)
  );

  assign atan_s  = atan_w;
  assign xi_ext  = {{(XY_W-16){i_x[15]}}, i_x};
  assign yi_ext  = {{(XY_W-16){i_y[15]}}, i_y};
  assign x_shift = x_q >>> iter_q;
  assign y_shift = y_q >>> iter_q;

  // Drive y toward zero; both updates use the pre-iteration x and y
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (!y_q[XY_W-1]) begin
      x_d = x_q + y_shift;
      y_d = y_q - x_shift;
      z_d = z_q + atan_s;
    end else begin
      x_d = x_q - y_shift;
      y_d = y_q + x_shift;
      z_d = z_q - atan_s;
    end
  end

  logic signed [PROD_W-1:0] x_ext, mag_prod, mag_full;
  logic [PROD_W-17:0]       unused_mag_bits;
  logic signed [31:0]       z_ext, deg_prod, deg_full;
  logic [15:0]              unused_deg_bits;
  logic [15:0]              angle_w;

  assign x_ext           = {{(PROD_W-XY_W){x_q[XY_W-1]}}, x_q};
  assign mag_prod        = x_ext * GAIN_EXT;
  assign mag_full        = mag_prod >>> 14;
  assign unused_mag_bits = mag_full[PROD_W-1:16];

  assign z_ext           = {{(32-Z_W){z_q[Z_W-1]}}, z_q};
  assign deg_prod        = z_ext * RAD2DEG_MUL + DEG_ROUND;
  assign deg_full        = deg_prod >>> RAD2DEG_SHIFT;
  assign unused_deg_bits = deg_full[31:16];
  assign angle_w         = deg_full[15:0] + offset_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      offset_q <= '0;
      zero_q   <= 1'b0;
      angle_q  <= '0;
      mag_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Left half-plane: rotate by 180 degrees first so CORDIC stays in range
            if (i_x[15]) begin
              x_q      <= -xi_ext;
              y_q      <= -yi_ext;
              offset_q <= i_y[15] ? -16'sd180 : 16'sd180;
            end else begin
              x_q      <= xi_ext;
              y_q      <= yi_ext;
              offset_q <= '0;
            end
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= (i_x == 16'h0000) && (i_y == 16'h0000);
            busy_q  <= 1'b1;
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == LAST_ITER) begin
            state_q <= ST_POST;
          end
        end
        ST_POST: begin
          angle_q <= zero_q ? 16'h0000 : angle_w;
          mag_q   <= zero_q ? 16'h0000 : mag_full[15:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign angle_output     = angle_q;
  assign magnitude_output = mag_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// Self-checking bench for cordic_atan2_mag against real-valued atan2/sqrt.
module tb_cordic_atan2_mag;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] i_x, i_y;
  logic [15:0] angle_output, magnitude_output;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_atan2_mag dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .i_x              (i_x),
    .i_y              (i_y),
    .angle_output     (angle_output),
    .magnitude_output (magnitude_output),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
    logic ok;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Angle comparison with wrap-around at +/-180 degrees
  task automatic check_angle(input string tag, input int obs, input real exp, input real tol);
    real d;
    logic ok;
    d = real'(obs) - exp;
    while (d > 180.0)  d = d - 360.0;
    while (d < -180.0) d = d + 360.0;
    ok = (d <= tol) && (d >= -tol);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0.2f +/- %0.1f", tag, obs, exp, tol);
    end
  endtask

  task automatic convert(input logic [15:0] x, input logic [15:0] y,
                         output int ang, output int mag, output int lat);
    @(negedge clk);
    i_x   = x;
    i_y   = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("busy_after_start", int'(busy), 1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    ang = int'($signed(angle_output));
    mag = int'(magnitude_output);
    check_eq("latency", lat, 17);
    @(posedge clk);
    #1 check_eq("done_single_cycle", int'(done), 0);
    $display("conv x=%h y=%h -> angle=%0d mag=%h lat=%0d", x, y, ang, mag[15:0], lat);
  endtask

  initial begin
    int   ang, mag, lat;
    int   ndone, done_at, first_ang;
    logic prev_done, dbl;
    real  r, rx, ry;
    int   xi, yi;
    logic [15:0] xr, yr;

    reset = 1'b1;
    start = 1'b0;
    i_x   = '0;
    i_y   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_angle", int'(angle_output), 0);
    check_eq("reset_mag", int'(magnitude_output), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    @(negedge clk) reset = 1'b0;

    convert(16'h4000, 16'h0000, ang, mag, lat);
    check_eq("a0_angle", ang, 0);
    check_tol("a0_mag", mag, 16384, 4);

    convert(16'h4000, 16'h4000, ang, mag, lat);
    check_eq("a45_angle", ang, 45);
    check_tol("a45_mag", mag, 23170, 8);
    repeat (5) @(posedge clk);
    #1 check_eq("hold_angle", int'($signed(angle_output)), 45);

    convert(16'hC000, 16'h0000, ang, mag, lat);
    check_eq("a180_angle", ang, 180);
    check_tol("a180_mag", mag, 16384, 4);

    convert(16'hC000, 16'hF000, ang, mag, lat);
    check_angle("a_m166_angle", ang, -166.0, 1.0);

    convert(16'h0000, 16'hC000, ang, mag, lat);
    check_angle("a_m90_angle", ang, -90.0, 1.0);
    check_tol("a_m90_mag", mag, 16384, 4);

    convert(16'h0000, 16'h0000, ang, mag, lat);
    check_eq("zero_angle", ang, 0);
    check_eq("zero_mag", mag, 0);

    convert(16'h8000, 16'h0000, ang, mag, lat);
    check_eq("xmin_angle", ang, 180);
    check_tol("xmin_mag", mag, 32768, 8);

    // Unit-vector sweep as produced by the sin/cos engine
    for (int d = -179; d <= 180; d++) begin
      r  = real'(d) * PI / 180.0;
      xi = int'(16384.0 * $cos(r));
      yi = int'(16384.0 * $sin(r));
      xr = xi[15:0];
      yr = yi[15:0];
      convert(xr, yr, ang, mag, lat);
      check_angle("sweep_angle", ang, real'(d), 1.0);
      check_tol("sweep_mag", mag, 16384, 8);
    end

    // Random vectors, kept away from the origin where angle resolution collapses
    for (int k = 0; k < 40; k++) begin
      xr = 16'($urandom);
      yr = 16'($urandom);
      for (int t = 0; t < 100; t++) begin
        rx = real'($signed(xr));
        ry = real'($signed(yr));
        if ($sqrt(rx * rx + ry * ry) >= 4096.0) break;
        xr = 16'($urandom);
        yr = 16'($urandom);
      end
      rx = real'($signed(xr));
      ry = real'($signed(yr));
      convert(xr, yr, ang, mag, lat);
      check_angle("rand_angle", ang, $atan2(ry, rx) * 180.0 / PI, 1.0);
      check_tol("rand_mag", mag, int'($sqrt(rx * rx + ry * ry)), 16);
    end

    // start pulsed mid-conversion must be ignored
    @(negedge clk);
    i_x   = 16'h4000;
    i_y   = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone     = 0;
    done_at   = 0;
    first_ang = 0;
    prev_done = 1'b0;
    dbl       = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin
        i_x = 16'hC000;
        i_y = 16'h0000;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (ndone == 0) begin
          done_at   = c;
          first_ang = int'($signed(angle_output));
        end
        ndone++;
      end
      if (done === 1'b1 && prev_done === 1'b1) dbl = 1'b1;
      prev_done = done;
    end
    start = 1'b0;
    $display("ignored-start run: done pulses=%0d at=%0d angle=%0d", ndone, done_at, first_ang);
    check_eq("ign_done_count", ndone, 1);
    check_eq("ign_done_at", done_at, 17);
    check_eq("ign_angle", first_ang, 45);
    check_eq("ign_no_double_done", int'(dbl), 0);

    // Reset during iteration 8 discards the result
    @(negedge clk);
    i_x   = 16'h0000;
    i_y   = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("rst_mid_angle", int'(angle_output), 0);
    check_eq("rst_mid_mag", int'(magnitude_output), 0);
    check_eq("rst_mid_busy", int'(busy), 0);
    check_eq("rst_mid_done", int'(done), 0);
    @(negedge clk) reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (done === 1'b1) ndone++;
    end
    $display("post-reset idle window: done pulses=%0d", ndone);
    check_eq("rst_no_done", ndone, 0);

    convert(16'hC000, 16'hF000, ang, mag, lat);
    check_angle("after_rst_angle", ang, -166.0, 1.0);
    check_tol("after_rst_mag", mag, 16888, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
